jtframe_dwnld_packer: RTL and testbench

Converts the byte-wide ioctl ROM-download stream from the I/O controller into the 16-bit masked prog_* write requests consumed by the SDRAM controller inside the frame. It sits directly upstream of the SDRAM ROM-load interface and drives prog_addr, prog_data, prog_mask and prog_we. A small FIFO absorbs ioctl bursts while the SDRAM is busy with refresh or game reads.

---
 rtl/jtframe_dwnld_pkg.sv | 28 ++
 rtl/jtframe_dwnld_fifo.sv | 48 ++++
 rtl/jtframe_dwnld_packer.sv | 135 +++++++++++++
 tb/tb_jtframe_dwnld_packer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and constants for the ROM download packer.
package jtframe_dwnld_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    localparam int unsigned EADDR_W  = 26;
    // Wide enough for eaddr[SDRAMW:0] with SDRAMW up to 23
    localparam int unsigned ENTRY_AW = 24;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [7:0]          data;
    } fifo_entry_t;

    localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    function automatic logic [1:0] byte_mask(input logic odd);
        return odd ? MASK_HI : MASK_LO;
    endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module jtframe_dwnld_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_c,
    output logic          full_c,
    output logic          empty_c
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned PW    = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_c;
    assign do_push = push_i && (!full_c || do_pop);
    assign rdata_c = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage needs no reset: pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/jtframe_dwnld_packer.sv
// Packs the byte-wide ioctl download stream into masked 16-bit SDRAM
// prog_* write requests, buffering bursts in a small FIFO.
module jtframe_dwnld_packer
    import jtframe_dwnld_pkg::*;
#(
    parameter int unsigned SDRAMW  = 22,
    parameter int unsigned HEADER  = 0,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_wr,
    output logic [SDRAMW-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic [1:0]        prog_mask,
    output logic              prog_we,
    input  logic              prog_rdy,
    output logic              dwnld_busy,
    output logic              ovf,
    output logic              range_err
);

    state_e            state_q;
    logic [SDRAMW-1:0] prog_addr_q;
    logic [15:0]       prog_data_q;
    logic [1:0]        prog_mask_q;
    logic              prog_we_q;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              range_err_q, range_err_d;
    logic              dl_q;

    logic [EADDR_W-1:0] eaddr_c;
    logic               hdr_ok_c;
    logic               in_range_c;
    logic               strobe_c;
    logic               push_c;
    logic               pop_c;
    logic               dl_rise_c;
    logic               fifo_full;
    logic               fifo_empty;
    fifo_entry_t        fifo_wdata;
    fifo_entry_t        fifo_rdata;
    logic               entry_unused;

    assign eaddr_c    = EADDR_W'(ioctl_addr) - EADDR_W'(HEADER);
    assign hdr_ok_c   = EADDR_W'(ioctl_addr) >= EADDR_W'(HEADER);
    // Word address eaddr[25:1] must fit below 2^SDRAMW
    assign in_range_c = (eaddr_c >> (SDRAMW + 1)) == '0;
    assign strobe_c   = ioctl_wr && downloading && hdr_ok_c;
    assign push_c     = strobe_c && in_range_c;
    assign pop_c      = (state_q == IDLE) && !fifo_empty;
    assign dl_rise_c  = downloading && !dl_q;

    assign fifo_wdata.addr = ENTRY_AW'(eaddr_c[SDRAMW:0]);
    assign fifo_wdata.data = ioctl_dout;
    assign entry_unused    = ^fifo_rdata.addr;

    jtframe_dwnld_fifo #(
        .DW (ENTRY_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i (fifo_wdata),
        .rdata_c (fifo_rdata),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    // Sticky flags clear only on a new download start
    always_comb begin
        ovf_d       = (ovf_q & ~dl_rise_c) | (push_c & fifo_full & ~pop_c);
        range_err_d = (range_err_q & ~dl_rise_c) | (strobe_c & ~in_range_c);
        busy_d      = downloading | ~fifo_empty | (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q       <= 1'b0;
            range_err_q <= 1'b0;
            busy_q      <= 1'b0;
            dl_q        <= 1'b0;
        end else begin
            ovf_q       <= ovf_d;
            range_err_q <= range_err_d;
            busy_q      <= busy_d;
            dl_q        <= downloading;
        end
    end

    // Request FSM: WRITE holds prog_* until prog_rdy, then one idle cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            prog_mask_q <= MASK_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        prog_addr_q <= fifo_rdata.addr[SDRAMW:1];
                        prog_data_q <= {fifo_rdata.data, fifo_rdata.data};
                        prog_mask_q <= byte_mask(fifo_rdata.addr[0]);
                        prog_we_q   <= 1'b1;
                        state_q     <= WRITE;
                    end
                end
                WRITE: begin
                    if (prog_rdy) begin
                        prog_we_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign prog_mask  = prog_mask_q;
    assign prog_we    = prog_we_q;
    assign dwnld_busy = busy_q;
    assign ovf        = ovf_q;
    assign range_err  = range_err_q;

endmodule

// File: tb/tb_jtframe_dwnld_packer.sv
// Scoreboard bench: two packer instances (HEADER=0 and HEADER=16).
module tb_jtframe_dwnld_packer;

    localparam int unsigned SDRAMW = 22;

    typedef struct packed {
        logic [SDRAMW-1:0] addr;
        logic [15:0]       data;
        logic [1:0]        mask;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              downloading;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wr;
    logic              ioctl_wr_h;
    logic [SDRAMW-1:0] prog_addr,  prog_addr_h;
    logic [15:0]       prog_data,  prog_data_h;
    logic [1:0]        prog_mask,  prog_mask_h;
    logic              prog_we,    prog_we_h;
    logic              prog_rdy,   prog_rdy_h;
    logic              dwnld_busy, dwnld_busy_h;
    logic              ovf,        ovf_h;
    logic              range_err,  range_err_h;

    int  checks = 0;
    int  errors = 0;
    bit  hold = 1'b0;
    int  rdy_delay = 3;
    int  rdy_cnt = 0;
    wr_t exp_a[$];
    wr_t exp_h[$];
    wr_t got_a, got_h;

    always #5 clk = ~clk;

    jtframe_dwnld_packer #(.SDRAMW(SDRAMW), .HEADER(0), .FIFO_AW(2)) dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prog_rdy(prog_rdy), .dwnld_busy(dwnld_busy),
        .ovf(ovf), .range_err(range_err)
    );

    jtframe_dwnld_packer #(.SDRAMW(SDRAMW), .HEADER(16), .FIFO_AW(2)) dut_h (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr_h),
        .prog_addr(prog_addr_h), .prog_data(prog_data_h), .prog_mask(prog_mask_h),
        .prog_we(prog_we_h), .prog_rdy(prog_rdy_h), .dwnld_busy(dwnld_busy_h),
        .ovf(ovf_h), .range_err(range_err_h)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d, input bit to_h);
        ioctl_addr = a;
        ioctl_dout = d;
        if (to_h) ioctl_wr_h = 1'b1;
        else      ioctl_wr   = 1'b1;
        @(posedge clk); #1;
        ioctl_wr   = 1'b0;
        ioctl_wr_h = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (!(exp_a.size() == 0 && exp_h.size() == 0 && !prog_we && !prog_we_h)) begin
            @(posedge clk); #1;
            n++;
            if (n >= maxc) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: %0d writes outstanding, expected 0",
                         exp_a.size() + exp_h.size());
                break;
            end
        end
    endtask

    // SDRAM model for dut: ack rdy_delay cycles after prog_we, unless held
    initial begin
        prog_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (prog_rdy) prog_rdy = 1'b0;
            else if (prog_we && !hold) begin
                rdy_cnt++;
                if (rdy_cnt >= rdy_delay) begin
                    prog_rdy = 1'b1;
                    rdy_cnt  = 0;
                end
            end else if (!prog_we) rdy_cnt = 0;
        end
    end

    initial begin
        prog_rdy_h = 1'b0;
        forever begin
            @(posedge clk); #1;
            prog_rdy_h = prog_we_h && !prog_rdy_h;
        end
    end

    // Monitor for dut
    initial begin
        bit we_prev = 1'b0;
        bit rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy_prev) check("a_we_drop_after_rdy", 32'(prog_we), 32'd0);
            if (prog_we && !we_prev) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_write: got addr %0h mask %0b, expected no write",
                             prog_addr, prog_mask);
                end else begin
                    got_a = exp_a.pop_front();
                    check("a_addr", 32'(prog_addr), 32'(got_a.addr));
                    check("a_data", 32'(prog_data), 32'(got_a.data));
                    check("a_mask", 32'(prog_mask), 32'(got_a.mask));
                end
            end
            we_prev  = prog_we;
            rdy_prev = prog_rdy;
        end
    end

    // Monitor for dut_h
    initial begin
        bit we_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (prog_we_h && !we_prev) begin
                if (exp_h.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL h_unexpected_write: got addr %0h mask %0b, expected no write",
                             prog_addr_h, prog_mask_h);
                end else begin
                    got_h = exp_h.pop_front();
                    check("h_addr", 32'(prog_addr_h), 32'(got_h.addr));
                    check("h_data", 32'(prog_data_h), 32'(got_h.data));
                    check("h_mask", 32'(prog_mask_h), 32'(got_h.mask));
                end
            end
            we_prev = prog_we_h;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        downloading = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        ioctl_wr = 1'b0;
        ioctl_wr_h = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we",   32'(prog_we),    32'd0);
        check("rst_addr", 32'(prog_addr),  32'd0);
        check("rst_data", 32'(prog_data),  32'd0);
        check("rst_mask", 32'(prog_mask),  32'd3);
        check("rst_ovf",  32'(ovf),        32'd0);
        check("rst_rerr", 32'(range_err),  32'd0);
        check("rst_busy", 32'(dwnld_busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        downloading = 1'b1;
        @(posedge clk); #1;

        // Single even byte, latency check
        exp_a.push_back('{22'h2, 16'hA5A5, 2'b10});
        strobe(25'h4, 8'hA5, 1'b0);
        check("t1_we_n+1", 32'(prog_we), 32'd0);
        @(posedge clk); #1;
        check("t1_we_n+2", 32'(prog_we), 32'd1);
        wait_drain(100);
        check("t1_busy_dl", 32'(dwnld_busy), 32'd1);

        // Odd byte and last in-range byte
        exp_a.push_back('{22'h3, 16'h3C3C, 2'b01});
        strobe(25'h7, 8'h3C, 1'b0);
        wait_drain(100);
        exp_a.push_back('{22'h3FFFFF, 16'h5A5A, 2'b01});
        strobe(25'h7FFFFF, 8'h5A, 1'b0);
        wait_drain(100);
        check("pre_burst_ovf", 32'(ovf), 32'd0);

        // Burst of 6 with ack withheld: 1 in WRITE, 4 buffered, 1 dropped
        hold = 1'b1;
        exp_a.push_back('{22'h8, 16'h6060, 2'b10});
        exp_a.push_back('{22'h8, 16'h6161, 2'b01});
        exp_a.push_back('{22'h9, 16'h6262, 2'b10});
        exp_a.push_back('{22'h9, 16'h6363, 2'b01});
        exp_a.push_back('{22'hA, 16'h6464, 2'b10});
        for (int i = 0; i < 6; i++) strobe(25'h10 + 25'(i), 8'h60 + 8'(i), 1'b0);
        check("burst_ovf", 32'(ovf), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("burst_we_held", 32'(prog_we), 32'd1);
        hold = 1'b0;
        wait_drain(300);
        check("burst_ovf_sticky", 32'(ovf), 32'd1);

        // Out-of-range byte
        strobe(25'h800000, 8'h77, 1'b0);
        check("range_err_set", 32'(range_err), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("range_no_we", 32'(prog_we), 32'd0);

        // Drain continues after downloading falls
        hold = 1'b1;
        exp_a.push_back('{22'h20, 16'h9999, 2'b10});
        strobe(25'h40, 8'h99, 1'b0);
        downloading = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_after_fall", 32'(dwnld_busy), 32'd1);
        hold = 1'b0;
        wait_drain(100);
        @(posedge clk); #1;
        check("busy_after_drain", 32'(dwnld_busy), 32'd0);
        check("range_err_kept", 32'(range_err), 32'd1);
        downloading = 1'b1;
        @(posedge clk); #1;
        check("range_err_clear", 32'(range_err), 32'd0);
        check("ovf_clear",       32'(ovf),       32'd0);

        // HEADER=16 instance: only bytes 16 and 17 produce writes
        exp_h.push_back('{22'h0, 16'h1010, 2'b10});
        exp_h.push_back('{22'h0, 16'h1111, 2'b01});
        for (int i = 0; i < 18; i++) strobe(25'(i), 8'(i), 1'b1);
        wait_drain(100);
        check("h_range_err", 32'(range_err_h), 32'd0);
        check("h_ovf",       32'(ovf_h),       32'd0);

        // Reset while in WRITE with 3 bytes queued
        hold = 1'b1;
        exp_a.push_back('{22'h18, 16'hC0C0, 2'b10});
        for (int i = 0; i < 4; i++) strobe(25'h30 + 25'(i), 8'hC0 + 8'(i), 1'b0);
        @(posedge clk); #1;
        check("pre_rst_we", 32'(prog_we), 32'd1);
        rst = 1'b1;
        downloading = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_we",   32'(prog_we),   32'd0);
        check("rst_mid_mask", 32'(prog_mask), 32'd3);
        @(posedge clk); #1;
        check("rst_mid_busy", 32'(dwnld_busy), 32'd0);
        rst = 1'b0;
        hold = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_we",      32'(prog_we),      32'd0);
        check("post_rst_busy",    32'(dwnld_busy),   32'd0);
        check("post_rst_pending", 32'(exp_a.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
